// File: rtl/lsu_dmem_access_ctrl_if.sv
// rtl/lsu_dmem_access_ctrl_if.sv - request, data-memory and response bundle for the LSU dmem controller
interface lsu_dmem_access_ctrl_if #(
  parameter int LINE_W = 128,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic              core_req_valid;
  logic              core_req_ready;
  logic              core_req_we;
  logic [1:0]        core_req_size;
  logic              core_req_unsigned;
  logic [AW-1:0]     core_req_addr;
  logic [DW-1:0]     core_req_wdata;

  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic              dbg_req_we;
  logic [1:0]        dbg_req_size;
  logic              dbg_req_unsigned;
  logic [AW-1:0]     dbg_req_addr;
  logic [DW-1:0]     dbg_req_wdata;

  logic              dmem_en;
  logic              dmem_we;
  logic [AW-5:0]     dmem_line_addr;
  logic [15:0]       dmem_be;
  logic [LINE_W-1:0] dmem_wdata;
  logic [LINE_W-1:0] dmem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic              resp_is_load;
  logic              resp_misaligned;
  logic [LINE_W-1:0] resp_line;
  logic              sel_lb;
  logic              sel_lh;
  logic              sel_lw;
  logic              sel_unsigned;
  logic [3:0]        sel_addr;

  modport master (
    output core_req_valid, core_req_we, core_req_size, core_req_unsigned, core_req_addr, core_req_wdata,
    output dbg_req_valid, dbg_req_we, dbg_req_size, dbg_req_unsigned, dbg_req_addr, dbg_req_wdata,
    output dmem_rdata, resp_ready,
    input  core_req_ready, dbg_req_ready,
    input  dmem_en, dmem_we, dmem_line_addr, dmem_be, dmem_wdata,
    input  resp_valid, resp_id, resp_is_load, resp_misaligned, resp_line,
    input  sel_lb, sel_lh, sel_lw, sel_unsigned, sel_addr
  );

  modport slave (
    input  core_req_valid, core_req_we, core_req_size, core_req_unsigned, core_req_addr, core_req_wdata,
    input  dbg_req_valid, dbg_req_we, dbg_req_size, dbg_req_unsigned, dbg_req_addr, dbg_req_wdata,
    input  dmem_rdata, resp_ready,
    output core_req_ready, dbg_req_ready,
    output dmem_en, dmem_we, dmem_line_addr, dmem_be, dmem_wdata,
    output resp_valid, resp_id, resp_is_load, resp_misaligned, resp_line,
    output sel_lb, sel_lh, sel_lw, sel_unsigned, sel_addr
  );
endinterface

// File: rtl/lsu_dmem_access_ctrl.sv
// rtl/lsu_dmem_access_ctrl.sv - round-robin core/debug arbiter and single-outstanding dmem access sequencer
module lsu_dmem_access_ctrl #(
  parameter int LINE_W = 128,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_dmem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RDWAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_dbg_q;
  logic              grant_dbg, accept, fault, ok_load, r_we, r_uns;
  logic [1:0]        r_size;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [15:0]       mask;
  logic [LINE_W-1:0] repl;

  always_comb begin
    state_d            = state_q;
    accept             = 1'b0;
    bus.core_req_ready = 1'b0;
    bus.dbg_req_ready  = 1'b0;
    bus.dmem_en        = 1'b0;
    bus.dmem_we        = 1'b0;
    bus.dmem_be        = '0;
    bus.dmem_wdata     = '0;
    bus.dmem_line_addr = '0;

    // Debug wins only when alone or when the core took the previous grant.
    grant_dbg = bus.dbg_req_valid & (~bus.core_req_valid | ~last_dbg_q);
    r_we      = grant_dbg ? bus.dbg_req_we       : bus.core_req_we;
    r_size    = grant_dbg ? bus.dbg_req_size     : bus.core_req_size;
    r_uns     = grant_dbg ? bus.dbg_req_unsigned : bus.core_req_unsigned;
    r_addr    = grant_dbg ? bus.dbg_req_addr     : bus.core_req_addr;
    r_wdata   = grant_dbg ? bus.dbg_req_wdata    : bus.core_req_wdata;

    fault   = (r_size == 2'd3) || (r_size == 2'd1 && r_addr[0]) || (r_size == 2'd2 && r_addr[1:0] != 2'b00);
    ok_load = ~fault & ~r_we;

    case (r_size)
      2'd0:    begin mask = 16'h0001; repl = {(LINE_W/8){r_wdata[7:0]}};   end
      2'd1:    begin mask = 16'h0003; repl = {(LINE_W/16){r_wdata[15:0]}}; end
      default: begin mask = 16'h000F; repl = {(LINE_W/32){r_wdata[31:0]}}; end
    endcase

    case (state_q)
      IDLE: begin
        if (rst_n) begin
          accept             = bus.core_req_valid | bus.dbg_req_valid;
          bus.core_req_ready = bus.core_req_valid & ~grant_dbg;
          bus.dbg_req_ready  = grant_dbg;
        end
        if (accept) begin
          bus.dmem_en        = ~fault;
          bus.dmem_we        = ~fault & r_we;
          bus.dmem_be        = (~fault & r_we) ? (mask << r_addr[3:0]) : 16'h0000;
          bus.dmem_wdata     = (~fault & r_we) ? repl : '0;
          bus.dmem_line_addr = fault ? '0 : r_addr[AW-1:4];
          state_d            = ok_load ? RDWAIT : RESP;
        end
      end
      RDWAIT:  state_d = RESP;
      RESP:    if (bus.resp_valid && bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      last_dbg_q          <= 1'b1;
      bus.resp_valid      <= 1'b0;
      bus.resp_id         <= 1'b0;
      bus.resp_is_load    <= 1'b0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_line       <= '0;
      bus.sel_lb          <= 1'b0;
      bus.sel_lh          <= 1'b0;
      bus.sel_lw          <= 1'b0;
      bus.sel_unsigned    <= 1'b0;
      bus.sel_addr        <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_dbg_q          <= grant_dbg;
        bus.resp_id         <= grant_dbg;
        bus.resp_is_load    <= ~r_we;
        bus.resp_misaligned <= fault;
        bus.sel_lb          <= ok_load && r_size == 2'd0;
        bus.sel_lh          <= ok_load && r_size == 2'd1;
        bus.sel_lw          <= ok_load && r_size == 2'd2;
        bus.sel_unsigned    <= ok_load & r_uns;
        bus.sel_addr        <= ok_load ? r_addr[3:0] : 4'h0;
        // Stores and faults respond next cycle; loads wait for the line.
        bus.resp_valid      <= ~ok_load;
      end
      if (state_q == RDWAIT) begin
        bus.resp_line  <= bus.dmem_rdata;
        bus.resp_valid <= 1'b1;
      end
      if (state_q == RESP && bus.resp_valid && bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_dmem_access_ctrl.sv
// tb/tb_lsu_dmem_access_ctrl.sv - randomized transaction-level check of lsu_dmem_access_ctrl
module tb_lsu_dmem_access_ctrl;
  localparam int LINE_W = 128;
  localparam int AW     = 32;
  localparam int DW     = 32;

  typedef struct {
    bit        v;
    bit        we;
    bit [1:0]  sz;
    bit        uns;
    bit [31:0] addr;
    bit [31:0] wd;
  } req_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   lg_dbg;

  lsu_dmem_access_ctrl_if #(.LINE_W(LINE_W), .AW(AW), .DW(DW)) bus ();

  lsu_dmem_access_ctrl #(.LINE_W(LINE_W), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_reqs(input req_t c, input req_t d);
    bus.core_req_valid    = c.v;
    bus.core_req_we       = c.we;
    bus.core_req_size     = c.sz;
    bus.core_req_unsigned = c.uns;
    bus.core_req_addr     = c.addr;
    bus.core_req_wdata    = c.wd;
    bus.dbg_req_valid     = d.v;
    bus.dbg_req_we        = d.we;
    bus.dbg_req_size      = d.sz;
    bus.dbg_req_unsigned  = d.uns;
    bus.dbg_req_addr      = d.addr;
    bus.dbg_req_wdata     = d.wd;
  endtask

  function automatic req_t mk(input bit v, input bit we, input bit [1:0] sz, input bit uns,
                              input bit [31:0] addr, input bit [31:0] wd);
    req_t r;
    r.v = v; r.we = we; r.sz = sz; r.uns = uns; r.addr = addr; r.wd = wd;
    return r;
  endfunction

  // Enters and leaves at one time unit after a rising edge, with the DUT idle.
  task automatic run_txn(input req_t c, input req_t d, input int stall);
    req_t         r;
    bit           gd, flt, ld, st;
    int           nb, off;
    logic [127:0] exp_wd, exp_line;
    logic [15:0]  exp_be;

    drive_reqs(c, d);
    bus.dmem_rdata = rand128();
    bus.resp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("idle_resp_valid", bus.resp_valid, 0);
    if (!c.v && !d.v) begin
      chk("none_core_ready", bus.core_req_ready, 0);
      chk("none_dbg_ready", bus.dbg_req_ready, 0);
      chk("none_dmem_en", bus.dmem_en, 0);
      tick();
      return;
    end
    gd  = d.v && (!c.v || !lg_dbg);
    r   = gd ? d : c;
    nb  = 1 << r.sz;
    off = int'(r.addr[3:0]);
    flt = (r.sz == 2'd3) || ((r.addr % nb) != 0);
    ld  = !r.we && !flt;
    st  = r.we && !flt;
    exp_be = st ? 16'(((1 << nb) - 1) << off) : 16'h0;
    exp_wd = '0;
    if (st) for (int i = 0; i < 16; i++) exp_wd[i*8 +: 8] = r.wd[(i % nb)*8 +: 8];

    chk("core_ready", bus.core_req_ready, !gd);
    chk("dbg_ready", bus.dbg_req_ready, gd);
    chk("dmem_en", bus.dmem_en, !flt);
    chk("dmem_we", bus.dmem_we, st);
    chk("dmem_be", bus.dmem_be, exp_be);
    chk("dmem_wdata", bus.dmem_wdata, exp_wd);
    chk("dmem_line_addr", bus.dmem_line_addr, flt ? 0 : (r.addr >> 4));
    lg_dbg = gd;
    tick();

    if (gd) d.v = 0; else c.v = 0;
    drive_reqs(c, d);
    if (ld) begin
      exp_line       = rand128();
      bus.dmem_rdata = exp_line;
      #1;
      chk("rdwait_resp_valid", bus.resp_valid, 0);
      chk("rdwait_dmem_en", bus.dmem_en, 0);
      chk("rdwait_core_ready", bus.core_req_ready, 0);
      chk("rdwait_dbg_ready", bus.dbg_req_ready, 0);
      tick();
    end else begin
      exp_line = '0;
    end

    for (int k = 0; k <= stall; k++) begin
      bus.resp_ready = (k == stall);
      bus.dmem_rdata = rand128();
      #1;
      chk("resp_valid", bus.resp_valid, 1);
      chk("resp_id", bus.resp_id, gd);
      chk("resp_misaligned", bus.resp_misaligned, flt);
      if (!flt) chk("resp_is_load", bus.resp_is_load, !r.we);
      if (ld) chk("resp_line", bus.resp_line, exp_line);
      chk("sel_lb", bus.sel_lb, ld && r.sz == 2'd0);
      chk("sel_lh", bus.sel_lh, ld && r.sz == 2'd1);
      chk("sel_lw", bus.sel_lw, ld && r.sz == 2'd2);
      if (ld || flt) begin
        chk("sel_unsigned", bus.sel_unsigned, ld && r.uns);
        chk("sel_addr", bus.sel_addr, ld ? off : 0);
      end
      chk("resp_core_ready", bus.core_req_ready, 0);
      chk("resp_dbg_ready", bus.dbg_req_ready, 0);
      chk("resp_dmem_en", bus.dmem_en, 0);
      tick();
    end
  endtask

  initial begin
    req_t c, d, none;
    vectors     = 0;
    miscompares = 0;
    lg_dbg      = 1'b1;
    none        = mk(0, 0, 0, 0, 0, 0);
    rst_n       = 1'b0;
    drive_reqs(none, none);
    bus.dmem_rdata = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_dmem_en", bus.dmem_en, 0);
    chk("rst_resp_line", bus.resp_line, 0);
    chk("rst_sel_lb", bus.sel_lb, 0);
    chk("rst_core_ready", bus.core_req_ready, 0);
    rst_n = 1'b1;
    tick();

    run_txn(mk(1, 0, 0, 1, 32'h0000_1005, 0), none, 0);
    run_txn(mk(1, 1, 1, 0, 32'h0000_0106, 32'h0000_BEEF), none, 0);
    run_txn(mk(1, 0, 2, 0, 32'h0000_0002, 0), none, 0);
    run_txn(none, mk(1, 0, 1, 0, 32'h0000_0003, 0), 0);
    for (int i = 0; i < 4; i++)
      run_txn(mk(1, 0, 2, 0, 32'h0000_0100, 0), mk(1, 1, 0, 0, 32'h0000_0207, 32'h0000_00A5), 0);
    run_txn(mk(1, 0, 1, 0, 32'h0000_300A, 0), none, 5);

    // Abandon a load mid-flight.
    c = mk(1, 0, 2, 0, 32'h0000_0040, 0);
    drive_reqs(c, none);
    #1;
    chk("pre_rst_dmem_en", bus.dmem_en, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", bus.resp_valid, 0);
    chk("midrst_dmem_en", bus.dmem_en, 0);
    chk("midrst_sel_lw", bus.sel_lw, 0);
    chk("midrst_core_ready", bus.core_req_ready, 0);
    chk("midrst_resp_line", bus.resp_line, 0);
    tick();
    drive_reqs(none, none);
    lg_dbg = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_resp_valid", bus.resp_valid, 0);
    end
    run_txn(mk(1, 1, 2, 0, 32'h0000_0010, 32'h1234_5678), mk(1, 0, 0, 0, 32'h0000_0020, 0), 0);

    for (int n = 0; n < 200; n++) begin
      c = mk(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      d = mk(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) c.addr[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) d.addr[1:0] = 2'b00;
      run_txn(c, d, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
